// File: rtl/tetris_pkg.sv
// Shared command codes, FSM state and pending-flag bundle for the tetris move scheduler.
// Also hosts the gravity-period and command-priority helpers used by the top.
package tetris_pkg;

  typedef enum logic [2:0] {
    CMD_NONE  = 3'd0,
    CMD_ROT   = 3'd1,
    CMD_LEFT  = 3'd2,
    CMD_RIGHT = 3'd3,
    CMD_SOFT  = 3'd4,
    CMD_GRAV  = 3'd5
  } cmd_t;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  typedef struct packed {
    logic rot;
    logic left;
    logic right;
    logic down;
    logic grav;
  } pend_t;

  // Gravity period in ticks, never faster than two ticks per row.
  function automatic int fall_period(input int base_fall, input logic [3:0] lvl);
    int p;
    p = base_fall - 2 * int'({28'd0, lvl});
    return (p < 2) ? 2 : p;
  endfunction

  function automatic cmd_t pick_cmd(input pend_t p);
    cmd_t c;
    if (p.rot)        c = CMD_ROT;
    else if (p.left)  c = CMD_LEFT;
    else if (p.right) c = CMD_RIGHT;
    else if (p.down)  c = CMD_SOFT;
    else if (p.grav)  c = CMD_GRAV;
    else              c = CMD_NONE;
    return c;
  endfunction

endpackage

// File: rtl/das_channel.sv
// One button's press edge plus delayed auto-shift repeat, paced by the game tick.
// Press/rpt are combinational one-cycle pulses; release clears the hold count; no backpressure.
module das_channel
  import tetris_pkg::*;
#(
  parameter int DAS_DELAY = 10,
  parameter int DAS_RATE  = 3
) (
  input  logic gm_clk,
  input  logic gm_rst_n,
  input  logic btn,
  input  logic tick,
  output logic press,
  output logic rpt
);

  localparam int MAXV = (DAS_DELAY > DAS_RATE) ? DAS_DELAY : DAS_RATE;
  localparam int CW   = (MAXV > 1) ? $clog2(MAXV) : 1;

  logic          btn_q;
  logic          rpt_mode;
  logic [CW-1:0] cnt;
  logic          limit_hit;

  assign press     = btn & ~btn_q;
  assign limit_hit = rpt_mode ? (cnt == CW'(DAS_RATE - 1)) : (cnt == CW'(DAS_DELAY - 1));
  assign rpt       = btn & ~press & tick & limit_hit;

  // The press cycle itself never counts as a held tick.
  always_ff @(posedge gm_clk or negedge gm_rst_n) begin
    if (!gm_rst_n) begin
      btn_q    <= 1'b0;
      rpt_mode <= 1'b0;
      cnt      <= '0;
    end else begin
      btn_q <= btn;
      if (!btn || press) begin
        cnt      <= '0;
        rpt_mode <= 1'b0;
      end else if (tick) begin
        if (limit_hit) begin
          cnt      <= '0;
          rpt_mode <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/tetris_move_scheduler.sv
// Turns buttons, DAS repeats and gravity into one-at-a-time core commands; 2 cycles pending->offer.
// cmd_valid/cmd hold until cmd_ready; new requests coalesce into one pending flag per source.
module tetris_move_scheduler
  import tetris_pkg::*;
#(
  parameter int TICK_DIV   = 1666667,
  parameter int BASE_FALL  = 30,
  parameter int DAS_DELAY  = 10,
  parameter int DAS_RATE   = 3,
  parameter int LEVEL_STEP = 1000
) (
  input  logic        gm_clk,
  input  logic        gm_rst_n,
  input  logic        down,
  input  logic        left,
  input  logic        right,
  input  logic        rott,
  input  logic        game_active,
  input  logic [15:0] score,
  output logic        cmd_valid,
  output cmd_t        cmd,
  input  logic        cmd_ready,
  output logic [3:0]  level
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GW = $clog2(BASE_FALL + 3);

  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [3:0]    level_q;
  logic [31:0]   threshold;
  logic          lvl_up;
  int            fall_per;
  logic [GW-1:0] grav_cnt;
  logic          grav_hit;
  logic          rott_q;
  logic          l_press, l_rpt, r_press, r_rpt, d_press, d_rpt;
  logic          both_held;
  pend_t         pend, set_p, clr_p, pend_nxt;
  state_t        state;
  cmd_t          cmd_q;
  logic          accept;

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge gm_clk or negedge gm_rst_n) begin
    if (!gm_rst_n) tick_cnt <= '0;
    else           tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
  end

  // Threshold keeps advancing after level saturates so it never re-fires on the same score.
  assign lvl_up = ({16'd0, score} >= threshold);

  always_ff @(posedge gm_clk or negedge gm_rst_n) begin
    if (!gm_rst_n) begin
      level_q   <= 4'd0;
      threshold <= 32'(LEVEL_STEP);
    end else if (lvl_up) begin
      threshold <= threshold + 32'(LEVEL_STEP);
      if (level_q != 4'd15) level_q <= level_q + 1'b1;
    end
  end

  always_comb begin
    fall_per = fall_period(BASE_FALL, level_q);
    grav_hit = tick && game_active && ((int'(32'(grav_cnt)) + 1) >= fall_per);
  end

  das_channel #(.DAS_DELAY(DAS_DELAY), .DAS_RATE(DAS_RATE)) u_das_left (
    .gm_clk   (gm_clk),
    .gm_rst_n (gm_rst_n),
    .btn      (left),
    .tick     (tick),
    .press    (l_press),
    .rpt      (l_rpt)
  );

  das_channel #(.DAS_DELAY(DAS_DELAY), .DAS_RATE(DAS_RATE)) u_das_right (
    .gm_clk   (gm_clk),
    .gm_rst_n (gm_rst_n),
    .btn      (right),
    .tick     (tick),
    .press    (r_press),
    .rpt      (r_rpt)
  );

  das_channel #(.DAS_DELAY(DAS_DELAY), .DAS_RATE(DAS_RATE)) u_das_down (
    .gm_clk   (gm_clk),
    .gm_rst_n (gm_rst_n),
    .btn      (down),
    .tick     (tick),
    .press    (d_press),
    .rpt      (d_rpt)
  );

  assign both_held = left & right;
  assign accept    = (state == ST_ISSUE) && cmd_ready;

  // Simultaneous left+right presses cancel each other; holding both silences repeats.
  always_comb begin
    set_p       = '0;
    set_p.rot   = rott & ~rott_q;
    set_p.left  = (l_press & ~r_press) | (l_rpt & ~both_held);
    set_p.right = (r_press & ~l_press) | (r_rpt & ~both_held);
    set_p.down  = d_press | d_rpt;
    set_p.grav  = grav_hit;
  end

  always_comb begin
    clr_p = '0;
    if (accept) begin
      case (cmd_q)
        CMD_ROT:   clr_p.rot   = 1'b1;
        CMD_LEFT:  clr_p.left  = 1'b1;
        CMD_RIGHT: clr_p.right = 1'b1;
        CMD_SOFT: begin
          clr_p.down = 1'b1;
          clr_p.grav = 1'b1;
        end
        CMD_GRAV:  clr_p.grav  = 1'b1;
        default:   clr_p       = '0;
      endcase
    end
  end

  assign pend_nxt = game_active ? pend_t'(set_p | (pend & ~clr_p)) : pend_t'('0);

  always_ff @(posedge gm_clk or negedge gm_rst_n) begin
    if (!gm_rst_n) begin
      pend   <= '0;
      rott_q <= 1'b0;
    end else begin
      pend   <= pend_nxt;
      rott_q <= rott;
    end
  end

  // A soft drop already moves the piece down, so it restarts the gravity period.
  always_ff @(posedge gm_clk or negedge gm_rst_n) begin
    if (!gm_rst_n) begin
      grav_cnt <= '0;
    end else if (!game_active || (accept && cmd_q == CMD_SOFT)) begin
      grav_cnt <= '0;
    end else if (tick) begin
      grav_cnt <= grav_hit ? '0 : grav_cnt + 1'b1;
    end
  end

  always_ff @(posedge gm_clk or negedge gm_rst_n) begin
    if (!gm_rst_n) begin
      state <= ST_IDLE;
      cmd_q <= CMD_NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (game_active && (|pend)) begin
            state <= ST_ISSUE;
            cmd_q <= pick_cmd(pend);
          end
        end
        ST_ISSUE: begin
          if (cmd_ready) begin
            state <= ST_IDLE;
            cmd_q <= CMD_NONE;
          end
        end
        default: begin
          state <= ST_IDLE;
          cmd_q <= CMD_NONE;
        end
      endcase
    end
  end

  assign cmd_valid = (state == ST_ISSUE);
  assign cmd       = cmd_q;
  assign level     = level_q;

endmodule

// File: tb/tb_tetris_move_scheduler.sv
// Scoreboarded bench for tetris_move_scheduler: expected commands are queued as stimulus is
// applied and matched at every accepted handshake; scenario tasks check timing and state.
module tb_tetris_move_scheduler;
  import tetris_pkg::*;

  logic        gm_clk;
  logic        gm_rst_n;
  logic        down, left, right, rott;
  logic        game_active;
  logic [15:0] score;
  logic        cmd_valid;
  cmd_t        cmd;
  logic        cmd_ready;
  logic [3:0]  level;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  cmd_t exp_q[$];
  cmd_t acc_cmd[$];
  int   acc_cyc[$];
  cmd_t mon_exp;

  tetris_move_scheduler #(
    .TICK_DIV   (4),
    .BASE_FALL  (30),
    .DAS_DELAY  (10),
    .DAS_RATE   (3),
    .LEVEL_STEP (1000)
  ) dut (
    .gm_clk      (gm_clk),
    .gm_rst_n    (gm_rst_n),
    .down        (down),
    .left        (left),
    .right       (right),
    .rott        (rott),
    .game_active (game_active),
    .score       (score),
    .cmd_valid   (cmd_valid),
    .cmd         (cmd),
    .cmd_ready   (cmd_ready),
    .level       (level)
  );

  initial begin
    gm_clk = 1'b0;
    forever #5 gm_clk = ~gm_clk;
  end

  always @(posedge gm_clk) cyc <= cyc + 1;

  // Every accepted command is matched against the head of the expectation queue.
  always @(negedge gm_clk) begin
    if (gm_rst_n && cmd_valid && cmd_ready) begin
      acc_cmd.push_back(cmd);
      acc_cyc.push_back(cyc);
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_cmd at cycle %0d: got %0d, wanted no command", cyc, cmd);
      end else begin
        mon_exp = exp_q.pop_front();
        if (cmd !== mon_exp) begin
          miscompares++;
          $display("FAIL scoreboard_cmd at cycle %0d: got %0d, wanted %0d", cyc, cmd, mon_exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge gm_clk);
    #1;
  endtask

  task automatic wait_acc(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (acc_cyc.size() >= target) break;
      step(1);
    end
    ok = (acc_cyc.size() >= target);
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (cmd_valid === 1'b1) break;
      step(1);
    end
    ok = (cmd_valid === 1'b1);
  endtask

  task automatic do_reset();
    gm_rst_n    = 1'b0;
    down        = 1'b0;
    left        = 1'b0;
    right       = 1'b0;
    rott        = 1'b0;
    game_active = 1'b0;
    score       = 16'd0;
    cmd_ready   = 1'b1;
    step(3);
    gm_rst_n = 1'b1;
    step(2);
    exp_q.delete();
    acc_cmd.delete();
    acc_cyc.delete();
  endtask

  task automatic test_reset();
    gm_rst_n = 1'b0; down = 0; left = 0; right = 0; rott = 0;
    game_active = 0; score = 16'd0; cmd_ready = 1'b1;
    step(2);
    vectors += 3;
    if (cmd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b, wanted 0", cmd_valid); end
    if (cmd !== CMD_NONE) begin miscompares++; $display("FAIL reset_cmd: got %0d, wanted 0", cmd); end
    if (level !== 4'd0) begin miscompares++; $display("FAIL reset_level: got %0d, wanted 0", level); end
    gm_rst_n = 1'b1;
    step(20);
    vectors += 2;
    if (cmd_valid !== 1'b0) begin miscompares++; $display("FAIL inactive_valid: got %b, wanted 0", cmd_valid); end
    if (acc_cyc.size() != 0) begin miscompares++; $display("FAIL inactive_cmds: got %0d, wanted 0", acc_cyc.size()); end
  endtask

  task automatic test_gravity();
    bit ok;
    do_reset();
    game_active = 1'b1;
    repeat (3) exp_q.push_back(CMD_GRAV);
    wait_acc(3, 420, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL grav_l0_count: got %0d accepts, wanted 3", acc_cyc.size()); end
    else begin
      vectors += 2;
      if (acc_cyc[1] - acc_cyc[0] != 120) begin miscompares++; $display("FAIL grav_l0_gap1: got %0d, wanted 120", acc_cyc[1] - acc_cyc[0]); end
      if (acc_cyc[2] - acc_cyc[1] != 120) begin miscompares++; $display("FAIL grav_l0_gap2: got %0d, wanted 120", acc_cyc[2] - acc_cyc[1]); end
    end
    score = 16'd3000;
    step(5);
    vectors++;
    if (level !== 4'd3) begin miscompares++; $display("FAIL level_3000: got %0d, wanted 3", level); end
    repeat (3) exp_q.push_back(CMD_GRAV);
    wait_acc(6, 350, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL grav_l3_count: got %0d accepts, wanted 6", acc_cyc.size()); end
    else begin
      for (int k = 3; k < 6; k++) begin
        vectors++;
        if (acc_cyc[k] - acc_cyc[k-1] != 96) begin
          miscompares++;
          $display("FAIL grav_l3_gap%0d: got %0d, wanted 96", k, acc_cyc[k] - acc_cyc[k-1]);
        end
      end
    end
    game_active = 1'b0;
    score = 16'd0;
    step(2);
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL grav_pending_exp: got %0d left, wanted 0", exp_q.size()); end
  endtask

  task automatic test_das_left();
    bit ok;
    do_reset();
    game_active = 1'b1;
    step(1);
    left = 1'b1;
    repeat (5) exp_q.push_back(CMD_LEFT);
    step(82);
    left = 1'b0;
    wait_acc(5, 20, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL das_count: got %0d accepts, wanted 5", acc_cyc.size()); end
    else begin
      vectors++;
      if (acc_cyc[1] - acc_cyc[0] < 37 || acc_cyc[1] - acc_cyc[0] > 40) begin
        miscompares++;
        $display("FAIL das_delay_gap: got %0d, wanted 37..40", acc_cyc[1] - acc_cyc[0]);
      end
      for (int k = 2; k < 5; k++) begin
        vectors++;
        if (acc_cyc[k] - acc_cyc[k-1] != 12) begin
          miscompares++;
          $display("FAIL das_rate_gap%0d: got %0d, wanted 12", k, acc_cyc[k] - acc_cyc[k-1]);
        end
      end
    end
    step(10);
    game_active = 1'b0;
    step(2);
    vectors += 2;
    if (acc_cyc.size() != 5) begin miscompares++; $display("FAIL das_total: got %0d, wanted 5", acc_cyc.size()); end
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL das_pending_exp: got %0d left, wanted 0", exp_q.size()); end
  endtask

  task automatic test_rot_left_clash();
    bit ok;
    do_reset();
    game_active = 1'b1;
    step(1);
    rott = 1'b1;
    left = 1'b1;
    exp_q.push_back(CMD_ROT);
    exp_q.push_back(CMD_LEFT);
    wait_acc(2, 20, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL rotleft_count: got %0d accepts, wanted 2", acc_cyc.size()); end
    else begin
      vectors++;
      if (acc_cyc[1] - acc_cyc[0] != 2) begin miscompares++; $display("FAIL rotleft_gap: got %0d, wanted 2", acc_cyc[1] - acc_cyc[0]); end
    end
    step(2);
    rott = 1'b0;
    left = 1'b0;
    step(5);
    left  = 1'b1;
    right = 1'b1;
    step(50);
    left  = 1'b0;
    right = 1'b0;
    step(10);
    vectors += 2;
    if (acc_cyc.size() != 2) begin miscompares++; $display("FAIL lr_clash_cmds: got %0d accepts, wanted 2", acc_cyc.size()); end
    if (cmd_valid !== 1'b0) begin miscompares++; $display("FAIL lr_clash_valid: got %b, wanted 0", cmd_valid); end
    game_active = 1'b0;
    step(2);
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL rotleft_pending_exp: got %0d left, wanted 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int bad;
    do_reset();
    game_active = 1'b1;
    cmd_ready   = 1'b0;
    step(1);
    left = 1'b1;
    exp_q.push_back(CMD_LEFT);
    exp_q.push_back(CMD_SOFT);
    wait_valid(10, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL bp_offer: got valid=%b, wanted 1", cmd_valid); end
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (i == 3)  left = 1'b0;
      if (i == 10) down = 1'b1;
      if (i == 13) down = 1'b0;
      if (cmd_valid !== 1'b1 || cmd !== CMD_LEFT) bad++;
    end
    vectors++;
    if (bad != 0) begin miscompares++; $display("FAIL bp_stable: got %0d unstable cycles, wanted 0", bad); end
    cmd_ready = 1'b1;
    wait_acc(2, 20, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL bp_count: got %0d accepts, wanted 2", acc_cyc.size()); end
    else begin
      vectors++;
      if (acc_cyc[1] - acc_cyc[0] != 2) begin miscompares++; $display("FAIL bp_soft_gap: got %0d, wanted 2", acc_cyc[1] - acc_cyc[0]); end
    end
    game_active = 1'b0;
    step(2);
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL bp_pending_exp: got %0d left, wanted 0", exp_q.size()); end
  endtask

  task automatic test_soft_over_grav();
    bit ok;
    do_reset();
    game_active = 1'b1;
    cmd_ready   = 1'b0;
    step(1);
    left = 1'b1;
    wait_valid(10, ok);
    step(3);
    left = 1'b0;
    step(130);
    down = 1'b1;
    step(3);
    down = 1'b0;
    step(2);
    exp_q.push_back(CMD_LEFT);
    exp_q.push_back(CMD_SOFT);
    exp_q.push_back(CMD_GRAV);
    cmd_ready = 1'b1;
    wait_acc(3, 200, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL softgrav_count: got %0d accepts, wanted 3", acc_cyc.size()); end
    else begin
      vectors++;
      if (acc_cyc[2] - acc_cyc[1] < 119 || acc_cyc[2] - acc_cyc[1] > 122) begin
        miscompares++;
        $display("FAIL softgrav_restart: got gap %0d, wanted 119..122", acc_cyc[2] - acc_cyc[1]);
      end
    end
    step(5);
    game_active = 1'b0;
    step(2);
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL softgrav_pending_exp: got %0d left, wanted 0", exp_q.size()); end
  endtask

  task automatic test_reset_abort();
    bit ok;
    do_reset();
    score       = 16'd3000;
    game_active = 1'b1;
    cmd_ready   = 1'b0;
    step(1);
    left = 1'b1;
    wait_valid(10, ok);
    step(2);
    left = 1'b0;
    vectors += 2;
    if (!ok) begin miscompares++; $display("FAIL abort_offer: got valid=%b, wanted 1", cmd_valid); end
    if (level !== 4'd3) begin miscompares++; $display("FAIL abort_level_pre: got %0d, wanted 3", level); end
    #2;
    gm_rst_n = 1'b0;
    #1;
    vectors += 3;
    if (cmd_valid !== 1'b0) begin miscompares++; $display("FAIL abort_valid: got %b, wanted 0", cmd_valid); end
    if (cmd !== CMD_NONE) begin miscompares++; $display("FAIL abort_cmd: got %0d, wanted 0", cmd); end
    if (level !== 4'd0) begin miscompares++; $display("FAIL abort_level: got %0d, wanted 0", level); end
    score = 16'd0;
    step(2);
    gm_rst_n  = 1'b1;
    cmd_ready = 1'b1;
    step(20);
    vectors++;
    if (acc_cyc.size() != 0) begin miscompares++; $display("FAIL abort_no_cmd: got %0d accepts, wanted 0", acc_cyc.size()); end
    cmd_ready = 1'b0;
    left = 1'b1;
    wait_valid(10, ok);
    step(2);
    left = 1'b0;
    rott = 1'b1;
    down = 1'b1;
    step(2);
    rott = 1'b0;
    down = 1'b0;
    game_active = 1'b0;
    step(3);
    exp_q.push_back(CMD_LEFT);
    cmd_ready = 1'b1;
    step(5);
    game_active = 1'b1;
    step(40);
    vectors += 2;
    if (acc_cyc.size() != 1) begin miscompares++; $display("FAIL inactive_flush: got %0d accepts, wanted 1", acc_cyc.size()); end
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL inactive_pending_exp: got %0d left, wanted 0", exp_q.size()); end
    game_active = 1'b0;
    step(2);
  endtask

  initial begin
    test_reset();
    test_gravity();
    test_das_left();
    test_rot_left_clash();
    test_backpressure();
    test_soft_over_grav();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
